// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler
//   Round-robin multi-zone irrigation controller. Serves one zone at a time.
//   A zone is served for a sprinkler or dripper duration chosen by its mode,
//   and each run is followed by an all-valves-closed gap. Irrigation halts
//   while the reservoir reports low water. All outputs are registered.
//
//   Ports
//     clk_i          system clock, rising edge
//     reset_i        synchronous, active-high reset
//     enable_i       1 = scheduler may irrigate
//     water_low_i    1 = reservoir below minimum level
//     zone_dry_i     per-zone service request
//     zone_mode_i    per-zone mode, 1 = sprinkler, 0 = dripper
//     valve_on_o     one-hot zone valve drive
//     splinker_on_o  global sprinkler line
//     dripper_on_o   global dripper line
//     active_zone_o  zone being served; holds the last value otherwise
//     status_code_o  00 idle/gap, 01 sprinkler, 10 dripper, 11 halted
//     busy_o         1 while in RUN or GAP
//     run_done_o     1-cycle pulse after a run completes its full duration
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for enable and a dry zone; valves closed
//   S_RUN  | one zone valve open, counter counts the run duration
//   S_GAP  | all valves closed for GAP_CYCLES before the next selection
//   S_HALT | water low; valves closed until water recovers or disable
module irrigation_scheduler #(
  parameter int N_ZONES          = 4,
  parameter int SPRINKLER_CYCLES = 20,
  parameter int DRIPPER_CYCLES   = 50,
  parameter int GAP_CYCLES       = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       water_low_i,
  input  logic [N_ZONES-1:0]         zone_dry_i,
  input  logic [N_ZONES-1:0]         zone_mode_i,
  output logic [N_ZONES-1:0]         valve_on_o,
  output logic                       splinker_on_o,
  output logic                       dripper_on_o,
  output logic [$clog2(N_ZONES)-1:0] active_zone_o,
  output logic [1:0]                 status_code_o,
  output logic                       busy_o,
  output logic                       run_done_o
);

  localparam int ZW      = $clog2(N_ZONES);
  localparam int MAX_SD  = (SPRINKLER_CYCLES > DRIPPER_CYCLES) ? SPRINKLER_CYCLES : DRIPPER_CYCLES;
  localparam int MAX_ALL = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] SPR_LOAD = CW'(SPRINKLER_CYCLES - 1);
  localparam logic [CW-1:0] DRP_LOAD = CW'(DRIPPER_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SPR  = 2'b01;
  localparam logic [1:0] ST_DRP  = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_HALT} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [ZW-1:0]       rr_q;
  logic [ZW-1:0]       active_zone_q;
  logic [N_ZONES-1:0]  valve_on_q;
  logic                splinker_q;
  logic                dripper_q;
  logic [1:0]          status_q;
  logic                busy_q;
  logic                run_done_q;

  logic                sel_found;
  logic [ZW-1:0]       sel_zone;
  logic                sel_mode;
  logic [N_ZONES-1:0]  sel_onehot;

  // (base + off) mod N_ZONES; works for non-power-of-two zone counts.
  function automatic logic [ZW-1:0] wrap_add(input logic [ZW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_ZONES) s = s - N_ZONES;
    return ZW'(s);
  endfunction

  // First dry zone scanning from the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_zone  = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      if (!sel_found && zone_dry_i[wrap_add(rr_q, i)]) begin
        sel_found = 1'b1;
        sel_zone  = wrap_add(rr_q, i);
      end
    end
    sel_mode   = zone_mode_i[sel_zone];
    sel_onehot = {{(N_ZONES-1){1'b0}}, 1'b1} << sel_zone;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rr_q          <= '0;
      active_zone_q <= '0;
      valve_on_q    <= '0;
      splinker_q    <= 1'b0;
      dripper_q     <= 1'b0;
      status_q      <= ST_IDLE;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i && water_low_i) begin
            state_q  <= S_HALT;
            status_q <= ST_HALT;
          end else if (enable_i && sel_found) begin
            state_q       <= S_RUN;
            active_zone_q <= sel_zone;
            cnt_q         <= sel_mode ? SPR_LOAD : DRP_LOAD;
            valve_on_q    <= sel_onehot;
            splinker_q    <= sel_mode;
            dripper_q     <= ~sel_mode;
            status_q      <= sel_mode ? ST_SPR : ST_DRP;
            busy_q        <= 1'b1;
          end
        end

        S_RUN: begin
          // Abort priority: disable beats water low beats counter expiry.
          if (!enable_i) begin
            state_q    <= S_IDLE;
            valve_on_q <= '0;
            splinker_q <= 1'b0;
            dripper_q  <= 1'b0;
            status_q   <= ST_IDLE;
            busy_q     <= 1'b0;
          end else if (water_low_i) begin
            state_q    <= S_HALT;
            valve_on_q <= '0;
            splinker_q <= 1'b0;
            dripper_q  <= 1'b0;
            status_q   <= ST_HALT;
            busy_q     <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q    <= S_GAP;
            cnt_q      <= GAP_LOAD;
            valve_on_q <= '0;
            splinker_q <= 1'b0;
            dripper_q  <= 1'b0;
            status_q   <= ST_IDLE;
            run_done_q <= 1'b1;
            // Only a completed run advances the pointer, so an aborted
            // zone is retried first.
            rr_q       <= wrap_add(active_zone_q, 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_GAP: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_HALT: begin
          if (!enable_i || !water_low_i) begin
            state_q  <= S_IDLE;
            status_q <= ST_IDLE;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          valve_on_q <= '0;
          splinker_q <= 1'b0;
          dripper_q  <= 1'b0;
          status_q   <= ST_IDLE;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign valve_on_o    = valve_on_q;
  assign splinker_on_o = splinker_q;
  assign dripper_on_o  = dripper_q;
  assign active_zone_o = active_zone_q;
  assign status_code_o = status_q;
  assign busy_o        = busy_q;
  assign run_done_o    = run_done_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler
//   Scenario-driven bench for irrigation_scheduler. Each scenario pushes the
//   runs it expects (zone, mode, length, completion, preceding gap) into a
//   queue; a negedge monitor reconstructs each valve-open episode from the
//   outputs and pops/compares it. Per-cycle invariants and point checks of
//   status/busy go through the same checking task.
module tb_irrigation_scheduler;

  localparam int N   = 4;
  localparam int SPR = 20;
  localparam int DRP = 50;
  localparam int GAP = 3;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         water_low;
  logic [N-1:0] zone_dry;
  logic [N-1:0] zone_mode;
  logic [N-1:0] valve_o;
  logic         splinker_on_o;
  logic         dripper_on_o;
  logic [1:0]   active_zone_o;
  logic [1:0]   status_code_o;
  logic         busy_o;
  logic         run_done_o;

  irrigation_scheduler #(
    .N_ZONES(N), .SPRINKLER_CYCLES(SPR), .DRIPPER_CYCLES(DRP), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .enable_i(enable),
    .water_low_i(water_low),
    .zone_dry_i(zone_dry),
    .zone_mode_i(zone_mode),
    .valve_on_o(valve_o),
    .splinker_on_o(splinker_on_o),
    .dripper_on_o(dripper_on_o),
    .active_zone_o(active_zone_o),
    .status_code_o(status_code_o),
    .busy_o(busy_o),
    .run_done_o(run_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int zone;
    int spr;
    int len;
    int done;
    int gap;   // -1 = don't care
  } run_t;

  run_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_runs   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_run(input int zone, input int spr, input int len, input int done, input int gap);
    run_t r;
    r.zone = zone; r.spr = spr; r.len = len; r.done = done; r.gap = gap;
    exp_q.push_back(r);
  endtask

  // Monitor: rebuild valve-open episodes and compare with the scoreboard.
  bit           in_run = 1'b0;
  int           run_len, run_zone, run_spr, run_gap;
  int           off_cnt = 0;
  logic [N-1:0] run_valve;

  always @(negedge clk) begin
    check_eq("inv_onehot", int'($onehot0(valve_o)), 1);
    check_eq("inv_excl", int'(splinker_on_o & dripper_on_o), 0);
    check_eq("inv_line", int'(splinker_on_o | dripper_on_o), int'(|valve_o));
    if (valve_o != '0) begin
      if (!in_run) begin
        in_run    = 1'b1;
        run_len   = 1;
        run_valve = valve_o;
        run_spr   = int'(splinker_on_o);
        run_gap   = off_cnt;
        run_zone  = 0;
        for (int i = 0; i < N; i++) if (valve_o[i]) run_zone = i;
        check_eq("run_active_zone", int'(active_zone_o), run_zone);
        check_eq("run_status", int'(status_code_o), run_spr ? 1 : 2);
        check_eq("run_busy", int'(busy_o), 1);
      end else begin
        run_len++;
        check_eq("valve_stable", int'(valve_o), int'(run_valve));
      end
      off_cnt = 0;
    end else begin
      if (in_run) begin
        run_t e;
        in_run = 1'b0;
        n_runs++;
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_run", run_zone, -1);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_zone", run_zone, e.zone);
          check_eq("sb_mode", run_spr, e.spr);
          check_eq("sb_len", run_len, e.len);
          check_eq("sb_run_done", int'(run_done_o), e.done);
          if (e.gap >= 0) check_eq("sb_gap", run_gap, e.gap);
        end
      end else begin
        check_eq("run_done_stray", int'(run_done_o), 0);
      end
      off_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input int bound);
    int k;
    k = 0;
    while (valve_o == '0 && k < bound) begin
      tick(1);
      k++;
    end
    if (valve_o == '0) check_eq("timeout_start", 0, 1);
  endtask

  task automatic wait_runs(input int target, input int bound);
    int k;
    k = 0;
    while (n_runs < target && k < bound) begin
      tick(1);
      k++;
    end
    if (n_runs < target) check_eq("timeout_runs", n_runs, target);
  endtask

  task automatic do_reset(input bit check_outputs);
    rst       = 1'b1;
    enable    = 1'b0;
    water_low = 1'b0;
    zone_dry  = '0;
    zone_mode = '0;
    tick(2);
    if (check_outputs) begin
      check_eq("rst_valve", int'(valve_o), 0);
      check_eq("rst_splinker", int'(splinker_on_o), 0);
      check_eq("rst_dripper", int'(dripper_on_o), 0);
      check_eq("rst_active_zone", int'(active_zone_o), 0);
      check_eq("rst_status", int'(status_code_o), 0);
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_run_done", int'(run_done_o), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; water_low = 1'b0; zone_dry = '0; zone_mode = '0;

    // Reset
    do_reset(1'b1);

    // Single sprinkler run, latency and gap length
    enable = 1'b1; zone_mode = 4'b0001; zone_dry = 4'b0001;
    push_run(0, 1, SPR, 1, -1);
    @(posedge clk); #1;
    check_eq("latency_valve", int'(valve_o), 1);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    check_eq("gap_busy_first", int'(busy_o), 1);
    check_eq("gap_status", int'(status_code_o), 0);
    tick(GAP - 1);
    check_eq("gap_busy_last", int'(busy_o), 1);
    tick(1);
    check_eq("gap_end_busy", int'(busy_o), 0);

    // Round robin, dripper
    do_reset(1'b0);
    enable = 1'b1; zone_mode = 4'b0000; zone_dry = 4'b1111;
    push_run(0, 0, DRP, 1, -1);
    push_run(1, 0, DRP, 1, GAP + 1);
    push_run(2, 0, DRP, 1, GAP + 1);
    push_run(3, 0, DRP, 1, GAP + 1);
    push_run(0, 0, DRP, 1, GAP + 1);
    wait_runs(n_runs + 4, 400);
    wait_start(20);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);

    // Water low at cycle 10 of zone 2, then retry from a full duration
    do_reset(1'b0);
    enable = 1'b1; zone_mode = 4'b0000; zone_dry = 4'b0100;
    push_run(2, 0, 10, 0, -1);
    wait_start(20);
    tick(9);
    water_low = 1'b1;
    tick(1);
    check_eq("halt_status", int'(status_code_o), 3);
    check_eq("halt_valve", int'(valve_o), 0);
    check_eq("halt_busy", int'(busy_o), 0);
    tick(3);
    check_eq("halt_hold_status", int'(status_code_o), 3);
    water_low = 1'b0;
    push_run(2, 0, DRP, 1, -1);
    wait_start(20);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);

    // Enable drop during zone 1 run; pointer must stay on zone 1
    do_reset(1'b0);
    enable = 1'b1; zone_mode = 4'b0011; zone_dry = 4'b0001;
    push_run(0, 1, SPR, 1, -1);
    wait_start(20);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);
    zone_dry = 4'b0010;
    push_run(1, 1, 5, 0, -1);
    wait_start(20);
    tick(4);
    enable = 1'b0; zone_dry = 4'b1111;
    tick(1);
    check_eq("abort_valve", int'(valve_o), 0);
    check_eq("abort_busy", int'(busy_o), 0);
    check_eq("abort_status", int'(status_code_o), 0);
    check_eq("abort_run_done", int'(run_done_o), 0);
    enable = 1'b1;
    push_run(1, 1, SPR, 1, -1);
    wait_start(20);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);

    // Water low coincident with counter expiry
    do_reset(1'b0);
    enable = 1'b1; zone_mode = 4'b0001; zone_dry = 4'b0001;
    push_run(0, 1, SPR, 0, -1);
    wait_start(20);
    zone_dry = '0;
    tick(SPR - 1);
    water_low = 1'b1;
    tick(1);
    check_eq("expiry_halt_status", int'(status_code_o), 3);
    check_eq("expiry_halt_run_done", int'(run_done_o), 0);
    water_low = 1'b0; zone_dry = 4'b1111;
    push_run(0, 1, SPR, 1, -1);
    wait_start(20);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);

    // Pointer wrap: zone 2 completes (rr=3), only zone 1 dry
    do_reset(1'b0);
    enable = 1'b1; zone_mode = 4'b0000; zone_dry = 4'b0100;
    push_run(2, 0, DRP, 1, -1);
    push_run(1, 0, DRP, 1, GAP + 1);
    wait_start(20);
    zone_dry = 4'b0010;
    wait_runs(n_runs + 1, 100);
    wait_start(20);
    check_eq("wrap_active_zone", int'(active_zone_o), 1);
    zone_dry = '0;
    wait_runs(n_runs + 1, 100);
    tick(GAP + 1);

    check_eq("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
